// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit
// Purpose  : Tracks the destination registers of the instructions in the EX,
//            MEM and WB stages of the 8-bit pipeline. From that state it
//            produces three kinds of control:
//              - operand forwarding selects for the execute stage,
//              - a one-cycle load-use stall,
//              - IF/ID and ID/EX flushes on a taken branch.
//            It also keeps a saturating count of stall cycles.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            id_*                  - decode-stage instruction fields
//            branch_taken          - taken branch resolved in EX
//            forward_a/forward_b   - 00 regfile, 01 EX/MEM ALU, 10 MEM/WB
//            stall                 - hold PC and IF/ID, bubble into EX
//            flush_if_id/_id_ex    - squash pipeline registers
//            stall_count           - saturating stall-cycle counter
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
  parameter int REG_AW  = 3,
  parameter bit R0_ZERO = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              branch_taken,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [CNT_W-1:0]  stall_count
);

  // EX stage record
  logic              ex_valid_q, ex_use_rs1_q, ex_use_rs2_q;
  logic              ex_reg_write_q, ex_mem_read_q;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  // MEM stage record
  logic              mem_valid_q, mem_reg_write_q, mem_mem_read_q;
  logic [REG_AW-1:0] mem_rd_q;
  // WB stage record
  logic              wb_valid_q, wb_reg_write_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              ex_valid_d;

  // A stage "writes" register r when it carries a real instruction that
  // writes rd == r. With R0_ZERO, r0 is hardwired and never produces a match.
  function automatic logic writes_reg(
    input logic              valid,
    input logic              reg_write,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] r
  );
    return valid && reg_write && (rd == r) && !(R0_ZERO && (r == '0));
  endfunction

  // Forward select for one operand. MEM has priority over WB, but a load
  // sitting in MEM has no ALU result worth forwarding, so it falls through
  // to the WB check.
  function automatic logic [1:0] fwd_sel(
    input logic              use_rs,
    input logic [REG_AW-1:0] rs
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && writes_reg(mem_valid_q, mem_reg_write_q, mem_rd_q, rs) && !mem_mem_read_q) begin
      sel = 2'b01;
    end else if (use_rs && writes_reg(wb_valid_q, wb_reg_write_q, wb_rd_q, rs)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    forward_a   = 2'b00;
    forward_b   = 2'b00;
    stall       = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst) begin
      if (ex_valid_q) begin
        forward_a = fwd_sel(ex_use_rs1_q, ex_rs1_q);
        forward_b = fwd_sel(ex_use_rs2_q, ex_rs2_q);
      end
      // Load in EX feeding the instruction in ID; the branch flush wins.
      stall = id_valid && !branch_taken && ex_mem_read_q &&
              ((id_use_rs1 && writes_reg(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs1)) ||
               (id_use_rs2 && writes_reg(ex_valid_q, ex_reg_write_q, ex_rd_q, id_rs2)));
      flush_if_id = branch_taken;
      flush_id_ex = branch_taken;
    end
  end

  always_comb begin
    ex_valid_d    = id_valid && !stall && !branch_taken;
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_rs1_q        <= '0;
      ex_rs2_q        <= '0;
      ex_use_rs1_q    <= 1'b0;
      ex_use_rs2_q    <= 1'b0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_reg_write_q  <= 1'b0;
      stall_count_q   <= '0;
    end else begin
      wb_valid_q      <= mem_valid_q;
      wb_rd_q         <= mem_rd_q;
      wb_reg_write_q  <= mem_reg_write_q;
      mem_valid_q     <= ex_valid_q;
      mem_rd_q        <= ex_rd_q;
      mem_reg_write_q <= ex_reg_write_q;
      mem_mem_read_q  <= ex_mem_read_q;
      ex_valid_q      <= ex_valid_d;
      ex_rs1_q        <= id_rs1;
      ex_rs2_q        <= id_rs2;
      ex_use_rs1_q    <= id_use_rs1;
      ex_use_rs2_q    <= id_use_rs2;
      ex_rd_q         <= id_rd;
      ex_reg_write_q  <= id_reg_write;
      ex_mem_read_q   <= id_mem_read;
      stall_count_q   <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Tracks destination-register state of the in-flight instructions in the EX, MEM and WB stages of the 8-bit pipeline.
- Generates the 2-bit forward selects that drive the two execute-stage operand forwarding muxes (00 = register file, 01 = ALU_Result from EX/MEM, 10 = Result from MEM/WB).
- Also detects load-use hazards, issues a one-cycle stall, flushes on taken branches, and keeps a saturating stall counter for performance debug.

Parameters:
- REG_AW, 3, register address width (8 architectural registers).
- R0_ZERO, 0, when 1, register 0 is hardwired and never matches for forwarding or stall.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1  in  REG_AW  decode source register A.
- id_rs2  in  REG_AW  decode source register B.
- id_use_rs1  in  1  decode instruction reads rs1.
- id_use_rs2  in  1  decode instruction reads rs2.
- id_rd  in  REG_AW  decode destination register.
- id_reg_write  in  1  decode instruction writes rd.
- id_mem_read  in  1  decode instruction is a load.
- branch_taken  in  1  taken branch resolved in EX this cycle.
- forward_a  out  2  select for operand A mux.
- forward_b  out  2  select for operand B mux.
- stall  out  1  hold PC and IF/ID, insert bubble into EX.
- flush_if_id  out  1  squash IF/ID contents.
- flush_id_ex  out  1  squash ID/EX contents.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Internal stage records:
  - EX: valid, rs1, rs2, use_rs1, use_rs2, rd, reg_write, mem_read.
  - MEM: valid, rd, reg_write, mem_read.
  - WB: valid, rd, reg_write.
- Per-cycle advance: WB <= MEM; MEM <= EX; EX <= ID fields, with EX.valid = id_valid & ~stall & ~branch_taken.
- A bubble (valid = 0) is inserted into EX on stall or branch_taken. MEM and WB always advance.
- Register-match rule: wr(S, r) = S.valid & S.reg_write & (S.rd == r) & ~(R0_ZERO & r == 0).
- forward_a, combinational from EX/MEM/WB registers only:
  - 01 if EX.use_rs1 & wr(MEM, EX.rs1) & ~MEM.mem_read;
  - else 10 if EX.use_rs1 & wr(WB, EX.rs1);
  - else 00.
  - MEM has priority over WB when both match.
  - forward_b is identical using rs2 and use_rs2.
- EX.valid = 0 forces both forward selects to 00.
- stall, combinational:
  - Asserted when id_valid & EX.valid & EX.mem_read & EX.reg_write and the load's rd matches id_rs1 (with id_use_rs1) or id_rs2 (with id_use_rs2); R0_ZERO applies.
  - Always exactly one cycle: the next cycle EX holds a bubble, so stall deasserts.
  - The load then reaches WB when the consumer is in EX, so the consumer gets forward 10.
  - Forward 01 never selects a load's ALU_Result.
- Branch:
  - branch_taken drives flush_if_id = flush_id_ex = 1 in the same cycle.
  - stall is forced to 0 when branch_taken = 1, because the flush wins.
- stall_count:
  - Increments on each rising edge where stall = 1.
  - Saturates at all-ones and never wraps.
- Reset:
  - While rst = 1: forward_a/b = 00, stall = 0, flush outputs = 0, regardless of inputs.
  - On the clock edge with rst = 1, all valid bits clear and stall_count = 0.
  - A reset asserted mid-stall or mid-flush discards that pending action. The first post-reset cycle sees an empty pipeline.
- No reset-free state. Latency: forward/stall/flush are valid in the same cycle as their inputs, with no added register stage.

Test Plan:
- Back-to-back ALU dependency: ADD r3 then SUB r4 = r3 - r1. When SUB is in EX -> forward_a = 01, forward_b = 00, stall = 0.
- Distance-2 dependency: ADD r3, NOP, OR r5 = r2 | r3. OR in EX -> forward_b = 10. With ADD r3 in MEM and another ADD r3 in WB -> forward = 01 (MEM priority).
- Load-use: LD r2 then ADD r6 = r2 + r2. Required sequence:
  - stall = 1 for exactly one cycle;
  - the next cycle EX holds a bubble with forward = 00;
  - ADD in EX shows forward_a = forward_b = 10;
  - stall_count goes from 0 to 1.
- Taken branch while a load-use hazard is present: branch_taken = 1 with LD r2 in EX and a consumer in ID -> flush_if_id = flush_id_ex = 1, stall = 0. Next cycle EX.valid = 0.
- R0_ZERO = 1: ADD r0 followed by a reader of r0 -> forward = 00. With R0_ZERO = 0 the same sequence -> 01.
- Reset and saturation:
  - Assert rst for one cycle while stall = 1 -> outputs 0 immediately; the next cycle the forward selects are 00 with the pipeline empty.
  - With CNT_W = 2, five consecutive load-use stalls -> stall_count stays at 3.
